// File: rtl/seq_detect_param.sv
// Moore serial-pattern detector with a runtime-programmable pattern (1..PAT_W bits),
// overlapping or non-overlapping matching, and a saturating match counter.
module seq_detect_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0000_0101),
  parameter int RST_LEN = 3,
  parameter logic RST_OVL = 1'b1,
  localparam int LEN_W = $clog2(PAT_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_vld,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             ovl_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_ld;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_next;
  logic             ovl;
  logic             accept;
  logic             match;
  logic [CNT_W-1:0] cnt_next;

  // Qualifier: x is consumed on a posedge only while x_vld is high; there is no
  // back-pressure. A config load in the same cycle wins and the bit is dropped.
  assign accept    = x_vld & ~pat_ld;
  assign hist_next = {hist[PAT_W-2:0], x};
  assign fill_next = (fill == FULL) ? FULL : fill + LEN_W'(1);
  assign len_ld    = ((len_in == '0) || (len_in > FULL)) ? FULL : len_in;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign match = accept && (fill_next >= len) && (((hist_next ^ pat) & mask) == '0);

  always_comb begin
    cnt_next = match_cnt;
    if (cnt_clr) begin
      cnt_next = match ? CNT_W'(1) : '0;
    end else if (match && (match_cnt != '1)) begin
      cnt_next = match_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat       <= RST_PAT;
      len       <= LEN_W'(RST_LEN);
      ovl       <= RST_OVL;
      hist      <= '0;
      fill      <= '0;
      y         <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      if (pat_ld) begin
        pat  <= pat_in;
        len  <= len_ld;
        ovl  <= ovl_in;
        hist <= '0;
        fill <= '0;
        y    <= 1'b0;
      end else if (x_vld) begin
        hist <= hist_next;
        // Non-overlap restarts the fill count so the next match needs len fresh bits.
        fill <= (match && !ovl) ? '0 : fill_next;
        y    <= match;
      end
      match_cnt <= cnt_next;
      cnt_sat   <= &cnt_next;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: main instance (CNT_W=8) plus a CNT_W=2
// instance sharing the same inputs for counter saturation.
module tb_seq_detect_param;

  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic       x_vld = 1'b0;
  logic       pat_ld = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic [3:0] len_in = 4'd0;
  logic       ovl_in = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       y;
  logic [7:0] match_cnt;
  logic       cnt_sat;
  logic       y2;
  logic [1:0] cnt2;
  logic       sat2;

  logic [CNT_W+1:0] exp_q[$];
  logic [2:0]       exp2_q[$];
  int n_cmp = 0;
  int n_err = 0;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .x(x), .x_vld(x_vld), .pat_ld(pat_ld),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
    .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .x_vld(x_vld), .pat_ld(pat_ld),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
    .y(y2), .match_cnt(cnt2), .cnt_sat(sat2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, input logic xb, input logic v,
                      input logic ld, input logic clr, input logic ey,
                      input logic [CNT_W-1:0] ec);
    logic [CNT_W+1:0] got;
    logic [CNT_W+1:0] e;
    @(negedge clk);
    rst = r; x = xb; x_vld = v; pat_ld = ld; cnt_clr = clr;
    exp_q.push_back({(&ec), ey, ec});
    @(posedge clk);
    #1;
    got = {cnt_sat, y, match_cnt};
    e = exp_q.pop_front();
    n_cmp++;
    assert (got === e) else begin
      n_err++;
      $error("FAIL %s {sat,y,cnt}: got %0b/%0b/%0d expected %0b/%0b/%0d",
             tag, got[CNT_W+1], got[CNT_W], got[CNT_W-1:0], e[CNT_W+1], e[CNT_W], e[CNT_W-1:0]);
    end
  endtask

  task automatic check2(input string tag);
    logic [2:0] e;
    e = exp2_q.pop_front();
    n_cmp++;
    assert ({sat2, cnt2} === e) else begin
      n_err++;
      $error("FAIL %s {sat2,cnt2}: got %0b/%0d expected %0b/%0d", tag, sat2, cnt2, e[2], e[1:0]);
    end
  endtask

  initial begin
    logic [7:0] pv;
    logic [1:0] c2;

    // reset
    step("rst0", 1, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0);

    // 1: defaults 101 / len 3 / overlap
    step("t1_b1", 0, 1, 1, 0, 0, 0, 0);
    step("t1_b2", 0, 0, 1, 0, 0, 0, 0);
    step("t1_b3", 0, 1, 1, 0, 0, 1, 1);
    step("t1_b4", 0, 0, 1, 0, 0, 0, 1);
    step("t1_b5", 0, 1, 1, 0, 0, 1, 2);

    // 2: non-overlap, counter cleared alongside the load
    pat_in = 8'h05; len_in = 4'd3; ovl_in = 1'b0;
    step("t2_ld", 0, 0, 0, 1, 1, 0, 0);
    step("t2_b1", 0, 1, 1, 0, 0, 0, 0);
    step("t2_b2", 0, 0, 1, 0, 0, 0, 0);
    step("t2_b3", 0, 1, 1, 0, 0, 1, 1);
    step("t2_b4", 0, 0, 1, 0, 0, 0, 1);
    step("t2_b5", 0, 1, 1, 0, 0, 0, 1);
    step("t2_b6", 0, 0, 1, 0, 0, 0, 1);
    step("t2_b7", 0, 1, 1, 0, 0, 1, 2);

    // 3: x_vld gaps, y holds through idle cycles
    pat_in = 8'h05; len_in = 4'd3; ovl_in = 1'b1;
    step("t3_ld", 0, 0, 0, 1, 1, 0, 0);
    step("t3_b1", 0, 1, 1, 0, 0, 0, 0);
    step("t3_g1", 0, 0, 0, 0, 0, 0, 0);
    step("t3_g2", 0, 1, 0, 0, 0, 0, 0);
    step("t3_b2", 0, 0, 1, 0, 0, 0, 0);
    step("t3_g3", 0, 1, 0, 0, 0, 0, 0);
    step("t3_g4", 0, 0, 0, 0, 0, 0, 0);
    step("t3_b3", 0, 1, 1, 0, 0, 1, 1);
    step("t3_h1", 0, 0, 0, 0, 0, 1, 1);
    step("t3_h2", 0, 1, 0, 0, 0, 1, 1);
    step("t3_b4", 0, 0, 1, 0, 0, 0, 1);

    // 4: full-width pattern 0xA7, then len_in=0 clamps to full width
    pv = 8'hA7;
    for (int pass = 0; pass < 2; pass++) begin
      pat_in = 8'hA7; ovl_in = 1'b1;
      len_in = (pass == 0) ? 4'd8 : 4'd0;
      step("t4_ld", 0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 16; i++) begin
        step((pass == 0) ? "t4_len8" : "t4_len0", 0, pv[7-(i%8)], 1, 0, 0,
             (i % 8) == 7, 8'((i + 1) / 8));
      end
    end

    // 5: len 1, saturation on the 2-bit counter instance, clr coincident with a match
    pat_in = 8'h01; len_in = 4'd1; ovl_in = 1'b1;
    exp2_q.push_back(3'b000);
    step("t5_ld", 0, 0, 0, 1, 1, 0, 0);
    check2("t5_ld2");
    c2 = 2'd0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) c2 = 2'd1;
      else if (c2 != 2'd3) c2 = c2 + 2'd1;
      exp2_q.push_back({(c2 == 2'd3), c2});
      step("t5_m", 0, 1, 1, 0, (i == 5), 1, (i == 5) ? 8'd1 : 8'(i));
      check2("t5_m2");
    end
    step("t5_zero", 0, 0, 1, 0, 0, 0, 1);
    pat_in = 8'h00; len_in = 4'd1; ovl_in = 1'b0;
    step("t5_ld0", 0, 0, 0, 1, 0, 0, 1);
    step("t5_n1", 0, 0, 1, 0, 0, 1, 2);
    step("t5_n2", 0, 0, 1, 0, 0, 1, 3);
    step("t5_n3", 0, 1, 1, 0, 0, 0, 3);

    // 6: rst overrides pat_ld; bit coincident with pat_ld is discarded
    pat_in = 8'h05; len_in = 4'd3; ovl_in = 1'b1;
    step("t6_ld", 0, 0, 0, 1, 1, 0, 0);
    step("t6_b1", 0, 1, 1, 0, 0, 0, 0);
    step("t6_b2", 0, 0, 1, 0, 0, 0, 0);
    step("t6_b3", 0, 1, 1, 0, 0, 1, 1);
    step("t6_b4", 0, 0, 1, 0, 0, 0, 1);
    pat_in = 8'hFF; len_in = 4'd1; ovl_in = 1'b0;
    step("t6_rst", 1, 1, 1, 1, 0, 0, 0);
    step("t6_def", 0, 1, 1, 0, 0, 0, 0);
    pat_in = 8'h05; len_in = 4'd3; ovl_in = 1'b1;
    step("t6_ldx", 0, 1, 1, 1, 0, 0, 0);
    step("t6_c1", 0, 0, 1, 0, 0, 0, 0);
    step("t6_c2", 0, 1, 1, 0, 0, 0, 0);
    step("t6_c3", 0, 0, 1, 0, 0, 0, 0);
    step("t6_c4", 0, 1, 1, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised Moore serial-pattern detector. It is the successor of the fixed-pattern detector FSM. It watches a qualified serial bitstream for a runtime-programmable pattern of length 1..PAT_W, in overlapping or non-overlapping mode. It provides a registered Moore match flag and a saturating match counter. It sits on serial front-end paths: framing, sync-word and preamble detection.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
RST_PAT, 8'b0000_0101, pattern loaded at reset (PAT_W bits)
RST_LEN, 3, pattern length loaded at reset (1..PAT_W)
RST_OVL, 1, overlap mode loaded at reset (1 = overlapping)
Derived localparam: LEN_W = $clog2(PAT_W+1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
x  in  1  serial data bit
x_vld  in  1  x is sampled only when high
pat_ld  in  1  load pattern configuration strobe
pat_in  in  PAT_W  new pattern; pat_in[len-1] is the first bit received, pat_in[0] the last
len_in  in  LEN_W  new pattern length
ovl_in  in  1  new overlap mode
cnt_clr  in  1  clear match counter
y  out  1  Moore match flag
match_cnt  out  CNT_W  number of matches detected, saturating
cnt_sat  out  1  match_cnt == all-ones

Behaviour:
- Reset (rst high at posedge):
  - pat=RST_PAT, len=RST_LEN, ovl=RST_OVL.
  - hist=0, fill=0, y=0, match_cnt=0, cnt_sat=0.
  - rst overrides every other input.
- Config:
  - On pat_ld, latch pat_in, len_in and ovl_in.
  - len_in of 0 or >PAT_W is latched as PAT_W.
  - pat_ld also clears hist, fill and y.
  - If pat_ld and x_vld are high in the same cycle, the bit is discarded.
  - match_cnt is unaffected by pat_ld.
- State:
  - hist[PAT_W-1:0] is a shift register; on x_vld, hist <= {hist[PAT_W-2:0], x}.
  - fill counts accepted bits and saturates at PAT_W.
  - x_vld low: hist, fill and y all hold. The FSM advances only on qualified bits.
- Match condition, evaluated on the post-shift values when x_vld is high and pat_ld is low:
  - fill_next >= len, and
  - hist_next[len-1:0] == pat[len-1:0].
- Moore output:
  - y <= match on every accepted bit. y goes high the cycle after the completing bit's posedge.
  - y stays high until the next accepted bit, pat_ld or rst.
  - y depends on registered state only; there is no combinational path from x to y.
- Overlap mode:
  - ovl=1: after a match, fill is kept, so a pattern suffix may start the next match.
  - ovl=0: after a match, fill is cleared to 0 (hist is not cleared). The next match needs len fresh bits.
- Counter:
  - On a match, match_cnt increments and saturates at 2^CNT_W-1.
  - cnt_sat is registered and is high exactly when match_cnt is all-ones.
  - cnt_clr alone: match_cnt <= 0.
  - cnt_clr in the same cycle as a match: match_cnt <= 1.
- len=1: every accepted bit equal to pat[0] is a match in either mode.
- Latency: 1 cycle from the accepted completing bit to y and match_cnt.

Test Plan:
1. Defaults (pattern 101, len 3, ovl=1), x_vld=1 every cycle, x = 1,0,1,0,1 -> y high after the 3rd and 5th bits only; match_cnt=2.
2. pat_ld with pat_in=101, len_in=3, ovl_in=0; same stream 1,0,1,0,1 -> y high after the 3rd bit only; match_cnt=1. Extending the stream with 0,1 (bits 6,7) -> second match after bit 7; match_cnt=2.
3. x_vld gaps: bits 1,0,1 interleaved with 2-cycle x_vld-low gaps -> one match; y stays high through the following idle cycles until the next accepted bit.
4. pat_ld with len_in=8, pat_in=8'hA7, ovl_in=1; feed 0xA7 MSB-first then 0xA7 again -> matches after bits 8 and 16 only. Repeat with len_in=0 -> identical result (clamped to PAT_W).
5. CNT_W=2 build: 5 matches -> match_cnt=3 and cnt_sat=1 after the 3rd match. cnt_clr coincident with the 5th match -> match_cnt=1, cnt_sat=0.
6. rst asserted after bits 1,0 of 101 and x_vld coincident with pat_ld -> all outputs 0. Subsequent 1 alone gives no match; full 1,0,1 is required for a match. The bit coincident with pat_ld is discarded.
